// File: rtl/seg_pkg.sv
// Shared glyph table, digit-select constants and handshake state type for the
// 4-digit multiplexed 7-segment scan controller.
package seg_pkg;

    // Active-low segments {dp, g..a}; dp is off in every glyph constant.
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [3:0] COM_OFF = 4'hF;

    typedef enum logic {
        IDLE,
        PENDING
    } hs_state_t;

    function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
        logic [7:0] g;
        g = SEG_OFF;
        case (nib)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble + decimal point to active-low {dp, g..a} segments.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Glyph constants carry dp off (bit 7 = 1), so masking bit 7 lights it.
    assign seg_o = {~dp_i, 7'h7F} & seg_glyph(nibble_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display: slot/frame timing,
// anti-ghost blanking, brightness, blink, and a frame-aligned req/ack word update.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SLOT_DIV     = 12500,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [15:0] wr_digits,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blink,
    input  logic [1:0]  bright,
    output logic        wr_ack,
    output logic        frame_tick,
    output logic [3:0]  com,
    output logic [7:0]  data
);

    localparam int SLOT_W  = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int Q       = (SLOT_DIV - BLANK_CYC) / 4;

    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_hidden_q, blink_hidden_d;
    hs_state_t          state_q, state_d;
    logic [15:0]        shadow_digits_q, active_digits_q;
    logic [3:0]         shadow_dp_q, active_dp_q;
    logic [3:0]         shadow_blink_q, active_blink_q;
    logic [3:0]         com_q, com_d;
    logic [7:0]         data_q, data_d;

    logic        slot_last, tick, capture, apply;
    logic        in_blank, in_lit;
    logic [31:0] slot_ext, lit_end;
    logic [3:0]  cur_nib;
    logic [7:0]  cur_seg;

    assign slot_last = (slot_cnt_q == SLOT_W'(SLOT_DIV - 1));
    assign tick      = slot_last && (idx_q == 2'd3);

    always_comb begin
        slot_cnt_d     = slot_last ? '0 : slot_cnt_q + SLOT_W'(1);
        idx_d          = slot_last ? idx_q + 2'd1 : idx_q;
        frame_cnt_d    = frame_cnt_q;
        blink_hidden_d = blink_hidden_q;
        if (tick) begin
            if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d    = '0;
                blink_hidden_d = ~blink_hidden_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    // The shadow is frozen while PENDING; the copy to active lands on the
    // frame-tick edge so the new word starts exactly at slot 0 of the next frame.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    capture = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (tick) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_nib = active_digits_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_dec (
        .nibble_i (cur_nib),
        .dp_i     (active_dp_q[idx_q]),
        .seg_o    (cur_seg)
    );

    assign slot_ext = 32'(slot_cnt_q);
    assign lit_end  = 32'(BLANK_CYC) + 32'(Q) * (32'(bright) + 32'd1);
    assign in_blank = (slot_ext < 32'(BLANK_CYC));
    assign in_lit   = !in_blank && (slot_ext < lit_end);

    always_comb begin
        com_d = COM_OFF;
        if (in_lit && !(blink_hidden_q && active_blink_q[idx_q])) begin
            com_d[idx_q] = 1'b0;
        end
        // Segments only move while every digit is dark, avoiding ghosting.
        data_d = in_blank ? cur_seg : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q      <= '0;
            idx_q           <= 2'd0;
            frame_cnt_q     <= '0;
            blink_hidden_q  <= 1'b0;
            state_q         <= IDLE;
            shadow_digits_q <= 16'h0000;
            shadow_dp_q     <= 4'h0;
            shadow_blink_q  <= 4'h0;
            active_digits_q <= 16'h0000;
            active_dp_q     <= 4'h0;
            active_blink_q  <= 4'h0;
            com_q           <= COM_OFF;
            data_q          <= SEG_OFF;
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            idx_q          <= idx_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_hidden_q <= blink_hidden_d;
            state_q        <= state_d;
            com_q          <= com_d;
            data_q         <= data_d;
            if (capture) begin
                shadow_digits_q <= wr_digits;
                shadow_dp_q     <= wr_dp;
                shadow_blink_q  <= wr_blink;
            end
            if (apply) begin
                active_digits_q <= shadow_digits_q;
                active_dp_q     <= shadow_dp_q;
                active_blink_q  <= shadow_blink_q;
            end
        end
    end

    assign com        = com_q;
    assign data       = data_q;
    assign wr_ack     = apply;
    assign frame_tick = tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SLOT_DIV=20, BLANK_CYC=4, BLINK_FRAMES=2.
// k counts clock edges since reset release; com/data at edge k reflect slot count k-1.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [15:0] wr_digits = 16'h0000;
    logic [3:0]  wr_dp = 4'h0;
    logic [3:0]  wr_blink = 4'h0;
    logic [1:0]  bright = 2'd3;
    logic        wr_ack;
    logic        frame_tick;
    logic [3:0]  com;
    logic [7:0]  data;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    seg_scan_ctrl #(
        .SLOT_DIV     (20),
        .BLANK_CYC    (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_digits  (wr_digits),
        .wr_dp      (wr_dp),
        .wr_blink   (wr_blink),
        .bright     (bright),
        .wr_ack     (wr_ack),
        .frame_tick (frame_tick),
        .com        (com),
        .data       (data)
    );

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_k(input int n);
        while (k < n) @(negedge clk);
    endtask

    task automatic test_reset();
        int lows, first_low, ticks, first_tick;
        lows = 0; first_low = -1; ticks = 0; first_tick = -1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (com !== 4'b1111 || data !== 8'hFF) begin
            n_fail++; $display("FAIL reset_outputs: com=%b data=%h, expected 1111/FF", com, data);
        end
        n_checks++;
        if (wr_ack !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: ack=%b tick=%b, expected 0/0", wr_ack, frame_tick);
        end
        reset = 1'b0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (com === 4'b1110 && k <= 40) begin
                lows++;
                if (first_low < 0) first_low = k;
            end
            if (frame_tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
            end
            if (k == 5) begin
                n_checks++;
                if (data !== 8'hC0) begin
                    n_fail++; $display("FAIL first_glyph: data=%h, expected C0", data);
                end
            end
        end
        n_checks++;
        if (first_low !== 5) begin
            n_fail++; $display("FAIL first_com_low: at edge %0d, expected 5", first_low);
        end
        n_checks++;
        if (lows !== 16) begin
            n_fail++; $display("FAIL digit0_lit_len: %0d cycles, expected 16", lows);
        end
        n_checks++;
        if (ticks !== 2 || first_tick !== 79) begin
            n_fail++; $display("FAIL frame_tick_rate: %0d ticks first at %0d, expected 2 at 79", ticks, first_tick);
        end
    endtask

    task automatic test_write();
        int ack_k;
        logic tick_at_ack;
        ack_k = -1; tick_at_ack = 1'b0;
        do_reset();
        wait_k(30);
        wr_req = 1'b1; wr_digits = 16'h1234; wr_dp = 4'h0; wr_blink = 4'h0;
        for (int i = 0; i < 200 && ack_k < 0; i++) begin
            @(negedge clk);
            if (k == 65) begin
                n_checks++;
                if (com !== 4'b0111 || data !== 8'hC0) begin
                    n_fail++; $display("FAIL old_frame_digit3: com=%b data=%h, expected 0111/C0", com, data);
                end
            end
            if (wr_ack === 1'b1) begin
                ack_k = k; tick_at_ack = frame_tick;
            end
        end
        wr_req = 1'b0;
        n_checks++;
        if (ack_k !== 79 || tick_at_ack !== 1'b1) begin
            n_fail++; $display("FAIL write_ack: ack at %0d tick=%b, expected 79 with tick", ack_k, tick_at_ack);
        end
        wait_k(85);
        n_checks++;
        if (com !== 4'b1110 || data !== 8'h99) begin
            n_fail++; $display("FAIL new_digit0: com=%b data=%h, expected 1110/99", com, data);
        end
        wait_k(105);
        n_checks++;
        if (com !== 4'b1101 || data !== 8'hB0) begin
            n_fail++; $display("FAIL new_digit1: com=%b data=%h, expected 1101/B0", com, data);
        end
        wait_k(145);
        n_checks++;
        if (com !== 4'b0111 || data !== 8'hF9) begin
            n_fail++; $display("FAIL new_digit3: com=%b data=%h, expected 0111/F9", com, data);
        end
    endtask

    task automatic test_bright();
        int cnt_a[4], cnt_b[4];
        int first_low, overlap;
        first_low = -1; overlap = 0;
        for (int d = 0; d < 4; d++) begin cnt_a[d] = 0; cnt_b[d] = 0; end
        bright = 2'd0;
        do_reset();
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if ($countones(~com) > 1) overlap++;
            for (int d = 0; d < 4; d++) begin
                if (com[d] === 1'b0) begin
                    if (k <= 80) cnt_a[d]++;
                    else         cnt_b[d]++;
                end
            end
            if (com[0] === 1'b0 && first_low < 0) first_low = k;
            if (k == 80) bright = 2'd2;
        end
        bright = 2'd3;
        n_checks++;
        if (first_low !== 5) begin
            n_fail++; $display("FAIL bright0_start: first low at %0d, expected 5", first_low);
        end
        n_checks++;
        if (overlap !== 0) begin
            n_fail++; $display("FAIL com_overlap: %0d cycles with >1 digit on, expected 0", overlap);
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (cnt_a[d] !== 4) begin
                n_fail++; $display("FAIL bright0_len digit%0d: %0d cycles, expected 4", d, cnt_a[d]);
            end
            n_checks++;
            if (cnt_b[d] !== 12) begin
                n_fail++; $display("FAIL bright2_len digit%0d: %0d cycles, expected 12", d, cnt_b[d]);
            end
        end
    endtask

    task automatic test_blink();
        int c0[8], c1[8];
        int acks, f;
        acks = 0;
        for (int i = 0; i < 8; i++) begin c0[i] = 0; c1[i] = 0; end
        do_reset();
        wr_req = 1'b1; wr_digits = 16'h0000; wr_dp = 4'h0; wr_blink = 4'b0001;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) begin acks++; wr_req = 1'b0; end
            f = (k - 1) / 80;
            if (com[0] === 1'b0) c0[f]++;
            if (com[1] === 1'b0) c1[f]++;
        end
        wr_req = 1'b0;
        n_checks++;
        if (acks !== 1) begin
            n_fail++; $display("FAIL blink_ack: %0d acks, expected 1", acks);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (c0[i] !== ((i == 2 || i == 3 || i == 6 || i == 7) ? 0 : 16)) begin
                n_fail++; $display("FAIL blink_digit0 frame%0d: %0d lit cycles", i, c0[i]);
            end
            n_checks++;
            if (c1[i] !== 16) begin
                n_fail++; $display("FAIL blink_digit1 frame%0d: %0d lit cycles, expected 16", i, c1[i]);
            end
        end
        wr_blink = 4'h0;
    endtask

    task automatic test_dp();
        int changes, bad_change;
        logic [7:0] prev;
        logic exp_dp;
        changes = 0; bad_change = 0;
        do_reset();
        prev = data;
        wr_req = 1'b1; wr_digits = 16'h0000; wr_dp = 4'b0100; wr_blink = 4'h0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) wr_req = 1'b0;
            if (data !== prev) begin
                changes++;
                if (((k - 1) % 20) >= 4) bad_change++;
            end
            prev = data;
            if (k > 80) begin
                exp_dp = (k >= 121 && k <= 140) ? 1'b0 : 1'b1;
                n_checks++;
                if (data[7] !== exp_dp) begin
                    n_fail++; $display("FAIL dp_bit at edge %0d: %b, expected %b", k, data[7], exp_dp);
                end
            end
        end
        wr_req = 1'b0; wr_dp = 4'h0;
        n_checks++;
        if (bad_change !== 0 || changes !== 3) begin
            n_fail++; $display("FAIL data_stability: %0d changes (%0d in lit window), expected 3 (0)", changes, bad_change);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        do_reset();
        wr_req = 1'b1; wr_digits = 16'hABCD;
        wait_k(20);
        reset = 1'b1; wr_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_ack === 1'b1) acks++;
        end
        n_checks++;
        if (com !== 4'b1111 || data !== 8'hFF) begin
            n_fail++; $display("FAIL midreset_outputs: com=%b data=%h, expected 1111/FF", com, data);
        end
        reset = 1'b0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) acks++;
            if (k == 5 || k == 25 || k == 45 || k == 65) begin
                n_checks++;
                if (data !== 8'hC0) begin
                    n_fail++; $display("FAIL midreset_glyph at edge %0d: data=%h, expected C0", k, data);
                end
            end
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL midreset_ack: %0d acks, expected 0", acks);
        end
    endtask

    task automatic test_back_to_back();
        int acks, ack1_k, ack2_k;
        acks = 0; ack1_k = -1; ack2_k = -1;
        wait_k(160);
        wr_req = 1'b1; wr_digits = 16'h5678;
        while (k < 320) begin
            @(negedge clk);
            if (wr_ack === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    ack1_k = k; wr_digits = 16'h9ABC;
                end else begin
                    ack2_k = k; wr_req = 1'b0;
                end
            end
        end
        wr_req = 1'b0;
        n_checks++;
        if (acks !== 2 || ack1_k !== 239 || ack2_k !== 319) begin
            n_fail++; $display("FAIL b2b_acks: %0d acks at %0d/%0d, expected 2 at 239/319", acks, ack1_k, ack2_k);
        end
        wait_k(325);
        n_checks++;
        if (data !== 8'hC6) begin
            n_fail++; $display("FAIL b2b_digit0: data=%h, expected C6", data);
        end
        wait_k(345);
        n_checks++;
        if (data !== 8'h83) begin
            n_fail++; $display("FAIL b2b_digit1: data=%h, expected 83", data);
        end
        wait_k(365);
        n_checks++;
        if (data !== 8'h88) begin
            n_fail++; $display("FAIL b2b_digit2: data=%h, expected 88", data);
        end
        wait_k(385);
        n_checks++;
        if (com !== 4'b0111 || data !== 8'h90) begin
            n_fail++; $display("FAIL b2b_digit3: com=%b data=%h, expected 0111/90", com, data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bright();
        test_blink();
        test_dp();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
